// File: rtl/reorder_buffer_pkg.sv
// Shared pipeline types: register/word types, the ROB entry layout, the
// rename map entry and the ROB geometry shared by dispatch, the functional
// units and retire.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int TAG_W    = $clog2(ROB_SIZE);

  typedef logic [4:0]       Register;
  typedef logic [31:0]      MemoryWord;
  typedef logic [TAG_W-1:0] rob_tag;

  typedef struct packed {
    Register    rd;
    logic [3:0] ctrl_bits;
    MemoryWord  value;
    logic       ready;
  } rob_entry;

  typedef struct packed {
    logic   busy;
    rob_tag tag;
  } map_table_entry;

endpackage

// File: rtl/reorder_buffer_if.sv
// Pipeline <-> reorder buffer bundle: dispatch allocation, CDB writeback
// and the head/decrement retire handshake.
//   master : pipeline side (dispatch, functional units, retire)
//   slave  : reorder buffer (owner of the entry storage)
interface reorder_buffer_if #(
  parameter int TAG_W = reorder_buffer_pkg::TAG_W
);
  import reorder_buffer_pkg::*;

  logic             alloc_valid;
  rob_entry         alloc_entry;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  MemoryWord        wb_value;
  rob_entry         rob_head;
  logic             rob_decrement;
  logic [TAG_W:0]   count;
  logic             empty;
  logic             full;

  modport master (
    output alloc_valid, alloc_entry, wb_valid, wb_tag, wb_value, rob_decrement,
    input  alloc_ready, alloc_tag, rob_head, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_entry, wb_valid, wb_tag, wb_value, rob_decrement,
    output alloc_ready, alloc_tag, rob_head, count, empty, full
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer owning the rob_entry storage.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   flush : synchronous squash of all entries (beats alloc, wb and pop)
//   rob   : slave side of the dispatch / writeback / retire bundle
// All outputs depend only on registered state.
module reorder_buffer #(
  parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE,
  parameter int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  reorder_buffer_if.slave  rob
);
  import reorder_buffer_pkg::*;

  rob_entry             mem [ROB_SIZE];
  logic [ROB_SIZE-1:0]  valid;
  logic [TAG_W-1:0]     head;
  logic [TAG_W-1:0]     tail;
  logic [TAG_W:0]       cnt;

  logic full_w;
  logic empty_w;
  logic alloc_fire;
  logic pop_fire;
  logic wb_fire;

  assign full_w  = (cnt == (TAG_W+1)'(ROB_SIZE));
  assign empty_w = (cnt == '0);

  // A pop never frees a slot for a same-cycle allocation: full is taken
  // from the registered count.
  assign alloc_fire = rob.alloc_valid && !full_w;
  assign pop_fire   = rob.rob_decrement && !empty_w;
  assign wb_fire    = rob.wb_valid && valid[rob.wb_tag];

  assign rob.full        = full_w;
  assign rob.empty       = empty_w;
  assign rob.alloc_ready = !full_w;
  assign rob.alloc_tag   = tail;
  assign rob.count       = cnt;
  assign rob.rob_head    = valid[head] ? mem[head] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      // Pop clears after the allocate set; the slots differ whenever both
      // fire, since allocation needs a non-full buffer.
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop_fire) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({alloc_fire, pop_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload needs no reset: rob_head is masked by valid. A writeback
  // racing a pop of the same entry lands in a slot that is being
  // invalidated, so the pop wins without extra gating.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (alloc_fire) begin
        mem[tail] <= rob.alloc_entry;
      end
      if (wb_fire) begin
        mem[rob.wb_tag].value <= rob.wb_value;
        mem[rob.wb_tag].ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(TAG_W)) rif ();

  reorder_buffer #(.ROB_SIZE(N), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .rob   (rif.slave)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: program-ordered queue of live entries, each tagged
  // with the slot it was allocated into.
  typedef struct {
    int unsigned tag;
    rob_entry    e;
  } m_t;

  m_t          mq[$];
  int unsigned m_tail = 0;
  bit          m_af;
  bit          m_pf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_tail = 0;
    end else if (flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      m_af = rif.alloc_valid && (mq.size() < N);
      m_pf = rif.rob_decrement && (mq.size() > 0);
      if (rif.wb_valid) begin
        foreach (mq[i]) begin
          if (mq[i].tag == int'(rif.wb_tag)) begin
            mq[i].e.value = rif.wb_value;
            mq[i].e.ready = 1'b1;
          end
        end
      end
      if (m_pf) void'(mq.pop_front());
      if (m_af) begin
        mq.push_back('{tag: m_tail, e: rif.alloc_entry});
        m_tail = (m_tail + 1) % N;
      end
    end
  end

  rob_entry exp_head;
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_head = (mq.size() > 0) ? mq[0].e : '0;
      chk("count",       rif.count,       64'(mq.size()));
      chk("empty",       rif.empty,       64'(mq.size() == 0));
      chk("full",        rif.full,        64'(mq.size() == N));
      chk("alloc_ready", rif.alloc_ready, 64'(mq.size() != N));
      chk("alloc_tag",   rif.alloc_tag,   64'(m_tail));
      chk("rob_head",    rif.rob_head,    64'(exp_head));
    end
  end

  function automatic rob_entry mk(input int unsigned rd, input bit rdy);
    rob_entry e;
    e           = '0;
    e.rd        = Register'(rd);
    e.ctrl_bits = 4'($urandom);
    e.value     = $urandom;
    e.ready     = rdy;
    return e;
  endfunction

  // Drive one cycle of inputs, then return just after the checking edge.
  task automatic go(input bit av = 0, input rob_entry e = '0, input bit wv = 0,
                    input int unsigned t = 0, input MemoryWord v = '0,
                    input bit dec = 0, input bit fl = 0);
    rif.alloc_valid   = av;
    rif.alloc_entry   = e;
    rif.wb_valid      = wv;
    rif.wb_tag        = TAG_W'(t);
    rif.wb_value      = v;
    rif.rob_decrement = dec;
    flush             = fl;
    @(negedge clk);
    #1;
  endtask

  int unsigned tg;
  int unsigned hd;
  int unsigned guard;

  initial begin
    rif.alloc_valid   = 1'b0;
    rif.alloc_entry   = '0;
    rif.wb_valid      = 1'b0;
    rif.wb_tag        = '0;
    rif.wb_value      = '0;
    rif.rob_decrement = 1'b0;
    #17;
    chk("rst_empty",       rif.empty, 1);
    chk("rst_full",        rif.full, 0);
    chk("rst_count",       rif.count, 0);
    chk("rst_head",        rif.rob_head, 0);
    chk("rst_alloc_tag",   rif.alloc_tag, 0);
    chk("rst_alloc_ready", rif.alloc_ready, 1);
    #5 rst_n = 1'b1;
    @(negedge clk);
    #1;
    cmp_en = 1'b1;

    // Single entry: allocate, write back, retire.
    go(.av(1), .e(mk(5, 0)));
    chk("t2_rd", rif.rob_head.rd, 5);
    chk("t2_ready0", rif.rob_head.ready, 0);
    chk("t2_model_count", mq.size(), 1);
    go(.wv(1), .t(0), .v(32'hDEAD));
    chk("t2_ready1", rif.rob_head.ready, 1);
    chk("t2_value", rif.rob_head.value, 32'hDEAD);
    go(.dec(1));
    chk("t2_empty", rif.empty, 1);

    // Fill to capacity, overflow attempt, pop+alloc while full.
    for (int i = 0; i < N; i++) go(.av(1), .e(mk(i, 0)));
    chk("t3_full", rif.full, 1);
    chk("t3_alloc_ready", rif.alloc_ready, 0);
    chk("t3_count", rif.count, 16);
    go(.av(1), .e(mk(31, 1)));
    chk("t3_overflow_count", rif.count, 16);
    chk("t3_tag_full", rif.alloc_tag, 1);
    go(.av(1), .e(mk(30, 1)), .dec(1));
    chk("t3_popalloc_count", rif.count, 15);
    chk("t3_popalloc_tag", rif.alloc_tag, 1);
    guard = 0;
    while (!rif.empty && guard < 20) begin go(.dec(1)); guard++; end
    chk("t3_drained", rif.empty, 1);

    // Wrap-around with out-of-order completion.
    for (int r = 0; r < 3; r++) begin
      hd = rif.alloc_tag;
      for (int i = 0; i < N; i++) begin
        tg = rif.alloc_tag;
        go(.av(1), .e(mk(i, 0)));
        if (tg == 15) chk("t4_tag_wrap", rif.alloc_tag, 0);
      end
      go(.wv(1), .t((hd + 3) % N), .v(32'h300 + r));
      go(.wv(1), .t((hd + 1) % N), .v(32'h100 + r));
      go(.wv(1), .t((hd + 2) % N), .v(32'h200 + r));
      go(.wv(1), .t(hd % N),       .v(32'h000 + r));
      for (int i = 0; i < N; i++) begin
        chk("t4_order", rif.rob_head.rd, i);
        if (i < 4) begin
          chk("t4_wb_ready", rif.rob_head.ready, 1);
          chk("t4_wb_value", rif.rob_head.value, 32'h100 * i + r);
        end
        go(.dec(1));
      end
      chk("t4_empty", rif.empty, 1);
    end

    // Same-cycle alloc+pop at count 4, then pop on empty.
    for (int i = 0; i < 4; i++) go(.av(1), .e(mk(10 + i, 0)));
    tg = rif.alloc_tag;
    go(.av(1), .e(mk(14, 0)), .dec(1));
    chk("t5_count", rif.count, 4);
    chk("t5_tail", rif.alloc_tag, (tg + 1) % N);
    chk("t5_head", rif.rob_head.rd, 11);
    for (int i = 0; i < 4; i++) go(.dec(1));
    tg = rif.alloc_tag;
    go(.dec(1));
    chk("t5_pop_empty_count", rif.count, 0);
    chk("t5_pop_empty_tag", rif.alloc_tag, tg);

    // Writeback to the head while it is popped: pop wins.
    go(.av(1), .e(mk(7, 0)));
    go(.av(1), .e(mk(8, 0)));
    go(.wv(1), .t(tg), .v(32'hBEEF), .dec(1));
    chk("t5_wbpop_rd", rif.rob_head.rd, 8);
    chk("t5_wbpop_ready", rif.rob_head.ready, 0);

    // Flush with same-cycle alloc and writeback.
    for (int i = 0; i < 6; i++) go(.av(1), .e(mk(i, 0)));
    chk("t6_count7", rif.count, 7);
    go(.av(1), .e(mk(9, 1)), .wv(1), .t(rif.alloc_tag - 1'b1), .v(32'h55), .fl(1));
    chk("t6_flush_count", rif.count, 0);
    chk("t6_flush_head", rif.rob_head, 0);
    chk("t6_flush_tag", rif.alloc_tag, 0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) go(.av(1), .e(mk(i, 1)));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_count", rif.count, 0);
    chk("t6_async_empty", rif.empty, 1);
    chk("t6_async_head", rif.rob_head, 0);
    chk("t6_async_tag", rif.alloc_tag, 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      go(.av($urandom_range(0, 9) < 6),
         .e(mk($urandom, $urandom_range(0, 1))),
         .wv($urandom_range(0, 1)),
         .t($urandom_range(0, N - 1)),
         .v($urandom),
         .dec($urandom_range(0, 1)),
         .fl($urandom_range(0, 99) == 0));
    end
    go();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer that owns the rob_entry storage. The dispatch stage writes entries at the tail. The writeback/CDB path marks entries complete by tag. The head entry is presented to the retire stage, which pops it by pulsing rob_decrement. This block is the writer/owner side of the rob_head / rob_decrement interface.

Parameters:
ROB_SIZE, 16, number of entries; must be a power of two and at least 2.
TAG_W, $clog2(ROB_SIZE), width of an entry index/tag.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
flush  input  1  synchronous squash of all entries.
alloc_valid  input  1  dispatch requests allocation of alloc_entry this cycle.
alloc_entry  input  rob_entry  entry to insert (rd, ctrl_bits, value, ready).
alloc_ready  output  1  space available; equals !full.
alloc_tag  output  TAG_W  tail index; the tag assigned if allocation occurs this cycle.
wb_valid  input  1  a functional unit reports a result.
wb_tag  input  TAG_W  entry being completed.
wb_value  input  MemoryWord  result value.
rob_head  output  rob_entry  entry at head; all-zero when empty.
rob_decrement  input  1  retire pops the head this cycle.
count  output  TAG_W+1  number of occupied entries.
empty  output  1  count == 0.
full  output  1  count == ROB_SIZE.

Behaviour:
- Storage: ROB_SIZE rob_entry registers, a per-entry valid bit, head and tail pointers of TAG_W bits, and a count register.
- Reset (reset==0, asynchronous):
  - head=0, tail=0, count=0, all valid bits=0.
  - Outputs: rob_head=0, empty=1, full=0, alloc_ready=1, alloc_tag=0, count=0.
- Outputs are combinational from registered state only; there are no input-to-output paths.
  - rob_head = valid[head] ? mem[head] : 0.
  - alloc_tag = tail.
- Allocate: fires when alloc_valid && !full (full from registered count).
  - mem[tail] <= alloc_entry, with the ready field taken as presented so no-result ops can be marked done at dispatch.
  - valid[tail] <= 1; tail <= tail+1, wrapping at ROB_SIZE naturally.
  - alloc_valid while full is ignored: no state change. Dispatch must stall on alloc_ready.
- Pop: fires when rob_decrement && !empty.
  - valid[head] <= 0; head <= head+1 with wrap.
  - rob_decrement while empty is ignored.
- A pop does not free a slot for same-cycle allocation. When full with pop+alloc in the same cycle, only the pop occurs.
- count update: count <= count + alloc_fire − pop_fire. Simultaneous alloc and pop leaves count unchanged.
- Writeback: if wb_valid && valid[wb_tag], set mem[wb_tag].value <= wb_value and mem[wb_tag].ready <= 1 next edge.
  - Writeback to an invalid entry is dropped.
  - Writeback to the head in the same cycle as a pop of that head: the pop wins and the entry is invalidated.
- Latency:
  - Allocated entry is visible at rob_head one cycle after the allocate edge, if the buffer was empty.
  - Writeback ready is visible one cycle after the wb edge.
- Flush: head=0, tail=0, count=0, all valid=0 at the next edge. Flush overrides same-cycle alloc, wb and pop.
- Reset mid-operation clears the buffer immediately regardless of clk.
- full and empty are derived from count, so the head==tail ambiguity is avoided.

Decomposition:
- rob_entry, Register, MemoryWord and map_table_entry stay in the shared types package.
- Add ROB_SIZE and a rob_tag typedef (logic [TAG_W-1:0]) to that package so dispatch, the functional units and retire share the tag width.
- No sub-module. Pointer/count logic and the entry array live in one module; a separate circular-pointer helper is not warranted.

Test Plan:
- Reset then idle: hold reset=0, release -> empty=1, full=0, count=0, rob_head=0, alloc_tag=0.
- Alloc rd=5 (ready=0), then wb_tag=0, wb_value=0xDEAD -> rob_head.rd=5 and ready=0 after cycle 1; ready=1 and value=0xDEAD after cycle 2; pop -> empty=1.
- Fill 16 entries -> full=1, alloc_ready=0; 17th alloc_valid ignored (count stays 16). Pop+alloc in the same cycle while full -> count=15, tail unchanged.
- Wrap-around: alloc 16 then pop 16, three times over, with out-of-order wb tags (3,1,2,0) -> head retires in program order; alloc_tag sequence wraps 15->0.
- Same-cycle alloc+pop with count=4 -> count stays 4, head+1, tail+1. rob_decrement while empty -> no change.
- Flush with count=7 plus same-cycle alloc and wb -> count=0, rob_head=0, alloc_tag=0 next cycle. Async reset asserted mid-cycle -> state cleared before the next edge.
